// File: rtl/vga_shadow_regs_pkg.sv
// Shared definitions for the VGA shadow register file: FSM encoding and the
// register-map addresses used by the time-keeping logic that fills the staging bank.
package vga_shadow_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_e;

    localparam int unsigned REG_UNUSED      = 0;
    localparam int unsigned REG_SEC         = 1;
    localparam int unsigned REG_MIN         = 2;
    localparam int unsigned REG_HOUR        = 3;
    localparam int unsigned REG_DAY         = 4;
    localparam int unsigned REG_MONTH       = 5;
    localparam int unsigned REG_YEAR        = 6;
    localparam int unsigned REG_CHRONO_SEC  = 7;
    localparam int unsigned REG_CHRONO_MIN  = 8;
    localparam int unsigned REG_CHRONO_HOUR = 9;
    localparam int unsigned REG_FLAGS_FIRST = 10;
    localparam int unsigned REG_FLAGS_LAST  = 15;

endpackage

// File: rtl/vga_vsync_edge.sv
// Falling-edge detector for the active-low VSync; history resets high so a
// line held low through reset does not look like a fresh edge.
module vga_vsync_edge (
    input  logic clk,
    input  logic rst,
    input  logic vsync_n,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = vsync_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~vsync_n;

endmodule

// File: rtl/vga_shadow_regs.sv
// Double-buffered register file: time-keeping logic writes the staging bank, and a
// commit copies it into the display bank one entry per cycle starting at vertical sync.
module vga_shadow_regs
    import vga_shadow_regs_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Commit,
    input  logic              VSync,
    input  logic [ADDR_W-1:0] MemAddrIn,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              Pending,
    output logic              Busy,
    output state_e            StateDbg
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              rearm_q, rearm_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] staging_q [DEPTH];
    logic [DATA_W-1:0] staging_d [DEPTH];
    logic [DATA_W-1:0] display_q [DEPTH];
    logic [DATA_W-1:0] display_d [DEPTH];
    logic              vsync_fall;

    vga_vsync_edge u_vsync_edge (
        .clk     (CLK),
        .rst     (RESET),
        .vsync_n (VSync),
        .fall    (vsync_fall)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rearm_q    <= 1'b0;
            mem_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                staging_q[i] <= '0;
                display_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rearm_q    <= rearm_d;
            mem_data_q <= mem_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                staging_q[i] <= staging_d[i];
                display_q[i] <= display_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rearm_d = rearm_q;
        case (state_q)
            ST_IDLE: begin
                if (Commit) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (vsync_fall) begin
                    state_d = ST_COPY;
                    idx_d   = '0;
                    rearm_d = 1'b0;
                end
            end
            ST_COPY: begin
                if (Commit) rearm_d = 1'b1;
                // A commit landing on the final copy cycle still re-arms.
                if (idx_q == LAST_IDX) begin
                    state_d = (rearm_q || Commit) ? ST_PENDING : ST_IDLE;
                    rearm_d = 1'b0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        staging_d  = staging_q;
        display_d  = display_q;
        if (WrEn && (state_q != ST_COPY)) staging_d[WrAddr] = WrData;
        if (state_q == ST_COPY) display_d[idx_q] = staging_q[idx_q];
        mem_data_d = display_q[MemAddrIn];
    end

    always_comb begin
        Pending    = (state_q == ST_PENDING);
        Busy       = (state_q == ST_COPY);
        StateDbg   = state_q;
        MemDataOut = mem_data_q;
    end

endmodule

// File: doc/vga_shadow_regs.md
VGA_SHADOW_REGS -- requirements
Module: vga_shadow_regs

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning register address width (2**ADDR_W entries).
REQ-002 SHALL have parameter DATA_W, default 8, meaning register data width.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 WrEn  input  1  staging-bank write strobe from time-keeping logic.
REQ-006 WrAddr  input  ADDR_W  staging-bank write address.
REQ-007 WrData  input  DATA_W  staging-bank write data.
REQ-008 Commit  input  1  one-cycle pulse requesting staging-to-display transfer.
REQ-009 VSync  input  1  active-low vertical sync from the VGA controller.
REQ-010 MemAddrIn  input  ADDR_W  display-bank read address from the VGA controller.
REQ-011 MemDataOut  output  DATA_W  display-bank read data, registered.
REQ-012 Pending  output  1  commit accepted, copy not yet started.
REQ-013 Busy  output  1  copy in progress.

Function
REQ-014 SHALL hold two banks of 2**ADDR_W x DATA_W registers: staging and display.
REQ-015 Read: MemDataOut SHALL equal display[MemAddrIn] sampled at the previous rising edge (one-cycle latency, every cycle, no enable).
REQ-016 Write: WrEn=1 with Busy=0 SHALL write WrData to staging[WrAddr] at the edge; WrEn while Busy=1 SHALL be ignored.
REQ-017 FSM states: IDLE, PENDING, COPY.
REQ-018 IDLE -> PENDING on Commit=1; Pending=1 in PENDING.
REQ-019 PENDING -> COPY on a VSync falling edge, detected by a registered copy of VSync (prev=1, now=0); copy index reset to 0.
REQ-020 COPY: each cycle display[idx] <= staging[idx], idx increments; after idx = 2**ADDR_W-1 is copied, return to IDLE; COPY lasts exactly 2**ADDR_W cycles; Busy=1 throughout.
REQ-021 Commit in PENDING SHALL be a no-op (stays PENDING).
REQ-022 Commit during COPY SHALL set a re-arm flag; on COPY exit go to PENDING instead of IDLE.
REQ-023 WrEn and Commit in the same cycle (IDLE or PENDING) SHALL include that write in the copied data.
REQ-024 VSync falling edge in IDLE or COPY SHALL be ignored (no copy start, no restart).
REQ-025 Reads during COPY SHALL return current display contents (entries below idx new, others old); acceptable since COPY starts at vertical blanking.
REQ-026 Copy index SHALL be ADDR_W bits and not wrap past the last entry.

Reset
REQ-027 RESET=1 SHALL immediately clear both banks to 0, MemDataOut to 0, Pending and Busy to 0, re-arm flag to 0, VSync history register to 1, state to IDLE.
REQ-028 RESET mid-COPY SHALL abandon the copy; no partial state survives.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding and the register-map address constants (0 unused, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year, 7-9 chrono sec/min/hour, 10-15 flags).
REQ-030 Single module, no sub-modules; optional sub-module vga_vsync_edge for the falling-edge detector.

Verification
REQ-031 Reset, then read all 16 addresses -> MemDataOut=0 each, one cycle after address.
REQ-032 Write staging[1]=30, [2]=15, [3]=3, Commit, VSync 1->0 -> Pending 1 until edge, Busy 16 cycles, then reads addr 1/2/3 give 30/15/3; before the edge addr 1 reads 0.
REQ-033 WrEn addr 4 data 4 during Busy -> after a second commit/copy, display[4] still 0.
REQ-034 Commit during COPY -> on COPY exit Pending=1; next VSync falling edge starts a second 16-cycle copy.
REQ-035 WrEn addr 8 data 50 with Commit same cycle, then VSync edge -> display[8]=50.
REQ-036 RESET asserted at copy cycle 5 -> immediately Busy=0, all reads 0, state IDLE.
